// File: rtl/ppu_bus_writer.sv
// rtl/ppu_bus_writer.sv - Command-FIFO-fed single-beat writer for the PPU slave port
// Define PPU_WR_VBLANK_GATE_EN to issue beats only while vblank_i is high.
module ppu_bus_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [1:0]                  cmd_table_i,
  input  logic [7:0]                  cmd_index_i,
  input  logic [31:0]                 cmd_data_i,
  input  logic                        vblank_i,
  output logic [31:0]                 writedata_o,
  output logic                        write_o,
  output logic                        chipselect_o,
  output logic [11:0]                 address_o,
  output logic                        busy_o,
  output logic                        err_drop_o,
  output logic [$clog2(FIFO_DEPTH):0] fill_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 44;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [3:0]    GAP_C   = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VB = 2'd1,
    S_WRITE   = 2'd2,
    S_GAP     = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    gap_q, gap_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [11:0]   address_q;
  logic [31:0]   wdata_q;
  logic          err_drop_q;

  logic          push, cmd_ok, store, drop, pop, gate_open;
  logic [EW-1:0] push_entry, head_entry;

  // Ready comes only from the registered count, so a same-cycle pop never raises it.
  assign cmd_ready_o = (count_q < DEPTH_C);
  assign push        = cmd_valid_i && cmd_ready_o;

  always_comb begin
    cmd_ok = 1'b1;
    if (cmd_table_i == 2'd3) begin
      cmd_ok = 1'b0;
    end else if ((cmd_table_i != 2'd1) && (cmd_index_i > 8'd15)) begin
      cmd_ok = 1'b0;
    end
  end

  assign store      = push && cmd_ok;
  assign drop       = push && !cmd_ok;
  assign push_entry = {1'b0, cmd_table_i, 1'b0, cmd_index_i, cmd_data_i};
  assign head_entry = mem_q[rd_ptr_q];

`ifdef PPU_WR_VBLANK_GATE_EN
  assign gate_open = vblank_i;
`else
  // Gate permanently open; vblank is folded in only to keep the port referenced.
  assign gate_open = vblank_i | 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (store) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({store, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (store) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_WAIT_VB;
        end
      end
      S_WAIT_VB: begin
        if (gate_open) begin
          pop     = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (GAP_CYCLES > 0) begin
          state_d = S_GAP;
          gap_d   = GAP_C - 4'd1;
        end else begin
          state_d = (count_q != '0) ? S_WAIT_VB : S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = (count_q != '0) ? S_WAIT_VB : S_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      gap_q      <= 4'd0;
      address_q  <= 12'd0;
      wdata_q    <= 32'd0;
      err_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      err_drop_q <= drop;
      // Bus address/data move only when a beat enters WRITE, then hold.
      if (pop) begin
        address_q <= head_entry[43:32];
        wdata_q   <= head_entry[31:0];
      end
    end
  end

  assign write_o      = (state_q == S_WRITE);
  assign chipselect_o = (state_q == S_WRITE);
  assign address_o    = address_q;
  assign writedata_o  = wdata_q;
  assign err_drop_o   = err_drop_q;
  assign fill_level_o = count_q;
  assign busy_o       = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_ppu_bus_writer.sv
// tb/tb_ppu_bus_writer.sv - Directed self-checking bench for ppu_bus_writer
module tb_ppu_bus_writer;
  localparam int DEPTH = 8;
  localparam int GAP   = 1;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_table = 2'd0;
  logic [7:0]    cmd_index = 8'd0;
  logic [31:0]   cmd_data = 32'd0;
  logic          vblank = 1'b0;
  logic [31:0]   writedata;
  logic          write;
  logic          chipselect;
  logic [11:0]   address;
  logic          busy;
  logic          err_drop;
  logic [FW-1:0] fill_level;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [11:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic        wr_cs[$];
  int          wr_cyc[$];

  ppu_bus_writer #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_table_i(cmd_table), .cmd_index_i(cmd_index), .cmd_data_i(cmd_data),
    .vblank_i(vblank), .writedata_o(writedata), .write_o(write),
    .chipselect_o(chipselect), .address_o(address), .busy_o(busy),
    .err_drop_o(err_drop), .fill_level_o(fill_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (write === 1'b1) begin
      wr_addr.push_back(address);
      wr_data.push_back(writedata);
      wr_cs.push_back(chipselect);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cs.delete(); wr_cyc.delete();
  endtask

  task automatic push(input logic [1:0] t, input logic [7:0] idx, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_table = t; cmd_index = idx; cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; vblank = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++; if ({write, chipselect, busy, err_drop, cmd_ready} !== 5'b00001) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 00001", {write, chipselect, busy, err_drop, cmd_ready});
    end
    checks++; if (address !== 12'd0) begin failures++; $display("FAIL reset_addr: got %h expected 000", address); end
    checks++; if (writedata !== 32'd0) begin failures++; $display("FAIL reset_data: got %h expected 0", writedata); end
    checks++; if (fill_level !== 4'd0) begin failures++; $display("FAIL reset_fill: got %0d expected 0", fill_level); end
  endtask

  task automatic test_single_write();
    int h;
    vblank = 1'b1; clear_log();
    push(2'd0, 8'd3, 32'h5A01_4064); h = cyc;
    repeat (6) @(posedge clk); #1;
    checks++; if (wr_addr.size() !== 1) begin failures++; $display("FAIL single_count: got %0d expected 1", wr_addr.size()); end
    if (wr_addr.size() >= 1) begin
      checks++; if (wr_cyc[0] !== h + 2) begin failures++; $display("FAIL single_latency: got %0d expected %0d", wr_cyc[0], h + 2); end
      checks++; if (wr_addr[0] !== 12'h003) begin failures++; $display("FAIL single_addr: got %h expected 003", wr_addr[0]); end
      checks++; if (wr_data[0] !== 32'h5A01_4064) begin failures++; $display("FAIL single_data: got %h expected 5a014064", wr_data[0]); end
      checks++; if (wr_cs[0] !== 1'b1) begin failures++; $display("FAIL single_cs: got %b expected 1", wr_cs[0]); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy: got %b expected 0", busy); end
    checks++; if (address !== 12'h003) begin failures++; $display("FAIL single_hold: got %h expected 003", address); end
  endtask

  task automatic test_pattern_table();
    vblank = 1'b1; clear_log();
    push(2'd1, 8'hFF, 32'hDEAD_BEEF);
    repeat (6) @(posedge clk); #1;
    checks++; if (wr_addr.size() !== 1) begin failures++; $display("FAIL pat_count: got %0d expected 1", wr_addr.size()); end
    if (wr_addr.size() >= 1) begin
      checks++; if (wr_addr[0] !== 12'h2FF) begin failures++; $display("FAIL pat_addr: got %h expected 2ff", wr_addr[0]); end
      checks++; if (wr_data[0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL pat_data: got %h expected deadbeef", wr_data[0]); end
    end
    checks++; if (address !== 12'h2FF) begin failures++; $display("FAIL pat_hold: got %h expected 2ff", address); end
  endtask

  task automatic test_drop();
    vblank = 1'b1; clear_log();
    push(2'd3, 8'd0, 32'h1111_1111);
    checks++; if (err_drop !== 1'b1) begin failures++; $display("FAIL drop_t3_pulse: got %b expected 1", err_drop); end
    checks++; if (fill_level !== 4'd0) begin failures++; $display("FAIL drop_t3_fill: got %0d expected 0", fill_level); end
    @(posedge clk); #1;
    checks++; if (err_drop !== 1'b0) begin failures++; $display("FAIL drop_t3_single: got %b expected 0", err_drop); end
    push(2'd2, 8'd16, 32'h2222_2222);
    checks++; if (err_drop !== 1'b1) begin failures++; $display("FAIL drop_idx_pulse: got %b expected 1", err_drop); end
    checks++; if (fill_level !== 4'd0) begin failures++; $display("FAIL drop_idx_fill: got %0d expected 0", fill_level); end
    @(posedge clk); #1;
    checks++; if (err_drop !== 1'b0) begin failures++; $display("FAIL drop_idx_single: got %b expected 0", err_drop); end
    repeat (6) @(posedge clk); #1;
    checks++; if (wr_addr.size() !== 0) begin failures++; $display("FAIL drop_no_write: got %0d expected 0", wr_addr.size()); end
    push(2'd2, 8'd15, 32'h000C_0105);
    checks++; if ({err_drop, fill_level} !== {1'b0, 4'd1}) begin
      failures++; $display("FAIL edge_idx_accept: got err=%b fill=%0d expected err=0 fill=1", err_drop, fill_level);
    end
    repeat (6) @(posedge clk); #1;
    checks++; if (wr_addr.size() !== 1) begin failures++; $display("FAIL edge_idx_count: got %0d expected 1", wr_addr.size()); end
    if (wr_addr.size() >= 1) begin
      checks++; if (wr_addr[0] !== 12'h40F) begin failures++; $display("FAIL edge_idx_addr: got %h expected 40f", wr_addr[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int accepted;
    int exp_n;
    logic rdy;
    accepted = 0; vblank = 1'b0; clear_log();
    for (int i = 0; i < 9; i++) begin
      cmd_valid = 1'b1; cmd_table = 2'd1; cmd_index = 8'(i); cmd_data = 32'hB000_0000 + 32'(i);
      rdy = cmd_ready;
      @(posedge clk); #1;
      if (rdy) accepted++;
    end
    cmd_valid = 1'b0;
`ifdef PPU_WR_VBLANK_GATE_EN
    exp_n = 8;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_full: got %b expected 0", cmd_ready); end
    checks++; if (fill_level !== 4'd8) begin failures++; $display("FAIL b2b_fill_full: got %0d expected 8", fill_level); end
    checks++; if (wr_addr.size() !== 0) begin failures++; $display("FAIL b2b_gated: got %0d expected 0", wr_addr.size()); end
    vblank = 1'b1;
`else
    exp_n = 9;
`endif
    checks++; if (accepted !== exp_n) begin failures++; $display("FAIL b2b_accepted: got %0d expected %0d", accepted, exp_n); end
    repeat (30) @(posedge clk); #1;
    checks++; if (wr_addr.size() !== exp_n) begin failures++; $display("FAIL b2b_count: got %0d expected %0d", wr_addr.size(), exp_n); end
    for (int i = 0; i < wr_addr.size() && i < exp_n; i++) begin
      checks++; if ({wr_addr[i], wr_data[i]} !== {12'h200 + 12'(i), 32'hB000_0000 + 32'(i)}) begin
        failures++; $display("FAIL b2b_order[%0d]: got %h/%h expected %h/%h", i, wr_addr[i], wr_data[i], 12'h200 + 12'(i), 32'hB000_0000 + 32'(i));
      end
      if (i > 0) begin
        checks++; if (wr_cyc[i] - wr_cyc[i-1] !== 3) begin failures++; $display("FAIL b2b_spacing[%0d]: got %0d expected 3", i, wr_cyc[i] - wr_cyc[i-1]); end
      end
    end
    checks++; if ({cmd_ready, busy, fill_level} !== {1'b1, 1'b0, 4'd0}) begin
      failures++; $display("FAIL b2b_drained: got ready=%b busy=%b fill=%0d expected 1/0/0", cmd_ready, busy, fill_level);
    end
  endtask

  task automatic test_vblank_gap();
    vblank = 1'b1; clear_log();
    push(2'd0, 8'd1, 32'h0000_000A);
    push(2'd0, 8'd2, 32'h0000_000B);
    push(2'd0, 8'd3, 32'h0000_000C);
    @(posedge clk); #1;
    vblank = 1'b0;
`ifdef PPU_WR_VBLANK_GATE_EN
    checks++; if ({write, 32'(wr_addr.size())} !== {1'b0, 32'd1}) begin
      failures++; $display("FAIL gap_in_gap: got write=%b writes=%0d expected 0/1", write, wr_addr.size());
    end
    repeat (10) @(posedge clk); #1;
    checks++; if (wr_addr.size() !== 1) begin failures++; $display("FAIL gap_held: got %0d expected 1", wr_addr.size()); end
    checks++; if ({busy, fill_level} !== {1'b1, 4'd2}) begin
      failures++; $display("FAIL gap_queued: got busy=%b fill=%0d expected 1/2", busy, fill_level);
    end
    vblank = 1'b1;
`endif
    repeat (12) @(posedge clk); #1;
    checks++; if (wr_addr.size() !== 3) begin failures++; $display("FAIL gap_count: got %0d expected 3", wr_addr.size()); end
    for (int i = 0; i < wr_addr.size() && i < 3; i++) begin
      checks++; if ({wr_addr[i], wr_data[i]} !== {12'(i + 1), 32'hA + 32'(i)}) begin
        failures++; $display("FAIL gap_order[%0d]: got %h/%h expected %h/%h", i, wr_addr[i], wr_data[i], 12'(i + 1), 32'hA + 32'(i));
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int n;
    logic [FW-1:0] exp_fill;
    clear_log();
`ifdef PPU_WR_VBLANK_GATE_EN
    vblank = 1'b0;
    for (int i = 0; i < 5; i++) push(2'd0, 8'(i), 32'h7000_0000 + 32'(i));
    vblank = 1'b1;
    exp_fill = 4'd4;
`else
    vblank = 1'b1;
    for (int i = 0; i < 5; i++) push(2'd0, 8'(i), 32'h7000_0000 + 32'(i));
    exp_fill = 4'd3;
`endif
    @(posedge clk); #1;
    checks++; if ({write, fill_level} !== {1'b1, exp_fill}) begin
      failures++; $display("FAIL rst_pre: got write=%b fill=%0d expected 1/%0d", write, fill_level, exp_fill);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if ({write, chipselect, fill_level} !== {1'b0, 1'b0, 4'd0}) begin
      failures++; $display("FAIL rst_mid: got write=%b cs=%b fill=%0d expected 0/0/0", write, chipselect, fill_level);
    end
    n = wr_addr.size();
    reset = 1'b0;
    repeat (20) @(posedge clk); #1;
    checks++; if (wr_addr.size() !== n) begin failures++; $display("FAIL rst_no_beats: got %0d expected %0d", wr_addr.size(), n); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_pattern_table();
    test_drop();
    test_back_to_back();
    test_vblank_gap();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ppu_bus_writer.md
Name: ppu_bus_writer

Overview:
- Bus initiator that drives the PPU's memory-mapped write port (writedata/write/chipselect/address) from an internal command FIFO.
- Game or control logic pushes table writes (sprite attribute, sprite pattern, colour) through a valid/ready handshake.
- The block serialises them into single-beat PPU writes, optionally only during vertical blanking so tables never change mid-scan.
- Sits between the HPS/game FSM and the ppu slave port.

Parameters:
- FIFO_DEPTH, 8, command FIFO entries; power of two, 2..64.
- GAP_CYCLES, 1, idle cycles after each write beat with address/writedata held stable; 0..15.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept a command this cycle
- cmd_table  in  2  0=sprite attribute table, 1=sprite pattern table, 2=colour table, 3=reserved
- cmd_index  in  8  entry index within table
- cmd_data  in  32  word to write
- vblank  in  1  high while the PPU raster is outside the active area (vcount >= 480)
- writedata  out  32  PPU write data
- write  out  1  PPU write strobe
- chipselect  out  1  PPU chip select
- address  out  12  PPU address
- busy  out  1  FIFO non-empty or a transaction in progress
- err_drop  out  1  one-cycle pulse when a command is discarded
- fill_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (synchronous, active-high, sampled on rising clk):
  - FIFO flushed; FSM to IDLE.
  - writedata, address, fill_level = 0; write, chipselect, busy, err_drop = 0; cmd_ready = 1 in the cycle after reset deasserts.
  - Reset mid-transaction: write/chipselect low on the next edge; no partial or repeated beat afterwards.
- Push:
  - Handshake completes when cmd_valid && cmd_ready on a rising edge.
  - cmd_ready = (fill_level < FIFO_DEPTH), from registered count only.
  - A pop in the same cycle does not raise ready until the next cycle.
  - Data is captured only on handshake; cmd_* may change freely while ready is low.
- Validation at push time; the command is not stored and err_drop pulses the next cycle when:
  - cmd_table == 3, or
  - cmd_table ∈ {0,2} and cmd_index > 15.
- Address: address[11:9] = {1'b0, cmd_table}; address[8] = 0; address[7:0] = cmd_index.
- FSM:
  - IDLE: if FIFO non-empty -> WAIT_VB.
  - WAIT_VB: when the gate is open (see Optional Feature), pop the head entry, load address and writedata -> WRITE.
  - WRITE: write = chipselect = 1 for exactly one cycle. Then -> GAP if GAP_CYCLES > 0, else -> IDLE or WAIT_VB per FIFO state.
  - GAP: write = chipselect = 0; address/writedata held; down-counter from GAP_CYCLES. At 0 -> WAIT_VB if non-empty, else IDLE.
- Throughput: one write per (1+GAP_CYCLES) cycles, plus one WAIT_VB cycle per beat.
- Latency: push into an empty FIFO with gate open -> write high on the 3rd rising edge after the handshake edge.
- address/writedata change only on entry to WRITE; they hold their last values in IDLE.
- Ordering is strict FIFO; no reordering or merging.
- vblank falling during GAP: the current beat completes; the next beat waits for the gate.
- busy = (fill_level != 0) || state != IDLE.
- Simultaneous push and pop: fill_level unchanged.
- Push when full is impossible because ready is low.

Optional Feature:
- Macro: PPU_WR_VBLANK_GATE_EN
- Defined: the gate is open only while vblank == 1, sampled in WAIT_VB. A beat that has entered WRITE always completes.
- Undefined: vblank is ignored, the gate is always open, and writes issue as soon as the FIFO is non-empty.

Test Plan:
- Reset, then push table=0 index=3 data=0x5A01_4064 with gate open -> write pulse 1 cycle, 3 edges after handshake; address=0x003, writedata=0x5A014064, chipselect=1; busy low after the gap.
- Push 9 commands back-to-back, FIFO_DEPTH=8, vblank=0 with gate enabled -> cmd_ready low after 8 accepts; fill_level=8; zero writes. Raise vblank -> 8 writes in push order, spaced 3 cycles apart (GAP_CYCLES=1), then ready high.
- Push table=3 index=0, then table=2 index=16 -> err_drop pulses once per command; fill_level stays 0; no write.
- Push table=1 index=0xFF data=0xDEADBEEF -> address=0x2FF, writedata=0xDEADBEEF for one write beat.
- Gate enabled: vblank drops during GAP with 2 entries queued -> current beat finishes; remaining entries wait; they are issued after vblank returns.
- Assert reset during WRITE with 4 entries queued -> write=0 next cycle; fill_level=0; no further beats after release.
